// File: rtl/debug_pkg.sv
// rtl/debug_pkg.sv - shared constants for the debug controller; frame size depends on DEBUG_CYCLE_COUNT_EN.
package debug_pkg;

    localparam logic [7:0] CMD_RUN   = 8'h63;
    localparam logic [7:0] CMD_STEP  = 8'h73;
    localparam logic [7:0] CMD_DUMP  = 8'h64;
    localparam logic [7:0] CMD_PAUSE = 8'h70;

    localparam int DEFAULT_DEBUG_W    = 322;
    localparam int DEFAULT_SNAP_BYTES = 41;
    localparam int CYC_CNT_BYTES      = 4;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_RUN     = 3'd1;
    localparam logic [2:0] ST_STEP    = 3'd2;
    localparam logic [2:0] ST_CAPTURE = 3'd3;
    localparam logic [2:0] ST_SEND    = 3'd4;

    function automatic int frame_bytes(input int snap_bytes);
`ifdef DEBUG_CYCLE_COUNT_EN
        return snap_bytes + CYC_CNT_BYTES;
`else
        return snap_bytes;
`endif
    endfunction

endpackage

// File: rtl/debug_tx_serializer.sv
// rtl/debug_tx_serializer.sv - frame shift register feeding the UART TX FIFO, MSB byte first.
module debug_tx_serializer #(
    parameter int FRAME_BYTES = 41
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     load,
    input  logic                     send_en,
    input  logic [8*FRAME_BYTES-1:0] frame_in,
    input  logic                     tx_full,
    output logic                     wr,
    output logic [7:0]               w_data,
    output logic                     done
);

    localparam int FRAME_W = 8 * FRAME_BYTES;
    localparam int CNT_W   = $clog2(FRAME_BYTES + 1);

    logic [FRAME_W-1:0] frame_q, frame_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [7:0]         w_data_q, w_data_d;

    assign wr   = send_en & ~tx_full;
    // w_data follows the top byte while writing and otherwise holds the last byte sent
    assign w_data = wr ? frame_q[FRAME_W-1 -: 8] : w_data_q;
    assign done = wr && (cnt_q == CNT_W'(FRAME_BYTES - 1));

    always_comb begin
        frame_d  = frame_q;
        cnt_d    = cnt_q;
        w_data_d = w_data_q;
        if (load) begin
            frame_d = frame_in;
            cnt_d   = '0;
        end else if (wr) begin
            frame_d  = frame_q << 8;
            cnt_d    = cnt_q + 1'b1;
            w_data_d = frame_q[FRAME_W-1 -: 8];
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            frame_q  <= '0;
            cnt_q    <= '0;
            w_data_q <= 8'h00;
        end else begin
            frame_q  <= frame_d;
            cnt_q    <= cnt_d;
            w_data_q <= w_data_d;
        end
    end

endmodule

// File: rtl/debug_controller.sv
// rtl/debug_controller.sv - UART command FSM that runs/steps/dumps the core and ships its snapshot.
// DEBUG_CYCLE_COUNT_EN appends a 32-bit enabled-cycle counter to every frame.
module debug_controller
    import debug_pkg::*;
#(
    parameter int DEBUG_W    = DEFAULT_DEBUG_W,
    parameter int SNAP_BYTES = DEFAULT_SNAP_BYTES
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [DEBUG_W-1:0] debug_signal,
    input  logic               cpu_halt,
    output logic               cpu_enable,
    input  logic               rx_empty,
    input  logic [7:0]         r_data,
    output logic               rd,
    input  logic               tx_full,
    output logic [7:0]         w_data,
    output logic               wr
);

    localparam int SNAP_W      = 8 * SNAP_BYTES;
    localparam int FRAME_BYTES = frame_bytes(SNAP_BYTES);
    localparam int FRAME_W     = 8 * FRAME_BYTES;

    logic [2:0]         state_q, state_d;
    logic [SNAP_W-1:0]  snap_w;
    logic [FRAME_W-1:0] frame_w;
    logic               load;
    logic               send_en;
    logic               done;

    // snapshot is left-aligned with zero padding in the low bits
    assign snap_w = SNAP_W'(debug_signal) << (SNAP_W - DEBUG_W);

`ifdef DEBUG_CYCLE_COUNT_EN
    logic [31:0] cyc_q;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            cyc_q <= 32'd0;
        end else if (cpu_enable) begin
            cyc_q <= cyc_q + 32'd1;
        end
    end

    assign frame_w = {snap_w, cyc_q};
`else
    assign frame_w = snap_w;
`endif

    assign rd = reset_n && !rx_empty && ((state_q == ST_IDLE) || (state_q == ST_RUN));

    always_comb begin
        state_d    = state_q;
        cpu_enable = 1'b0;
        load       = 1'b0;
        send_en    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (rd) begin
                    case (r_data)
                        CMD_RUN:  state_d = ST_RUN;
                        CMD_STEP: state_d = ST_STEP;
                        CMD_DUMP: state_d = ST_CAPTURE;
                        default:  state_d = ST_IDLE;
                    endcase
                end
            end
            ST_RUN: begin
                cpu_enable = !cpu_halt;
                // halt and a popped pause collapse into a single capture
                if (cpu_halt || (rd && (r_data == CMD_PAUSE))) begin
                    state_d = ST_CAPTURE;
                end
            end
            ST_STEP: begin
                cpu_enable = 1'b1;
                state_d    = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                load    = 1'b1;
                state_d = ST_SEND;
            end
            ST_SEND: begin
                send_en = 1'b1;
                if (done) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    debug_tx_serializer #(
        .FRAME_BYTES(FRAME_BYTES)
    ) u_tx (
        .clock    (clock),
        .reset_n  (reset_n),
        .load     (load),
        .send_en  (send_en),
        .frame_in (frame_w),
        .tx_full  (tx_full),
        .wr       (wr),
        .w_data   (w_data),
        .done     (done)
    );

endmodule

// File: tb/tb_debug_controller.sv
// tb/tb_debug_controller.sv - table-driven bench for debug_controller (DEBUG_CYCLE_COUNT_EN aware).
module tb_debug_controller;

    localparam int DW = 322;
    localparam int SB = 41;
`ifdef DEBUG_CYCLE_COUNT_EN
    localparam int FB = SB + 4;
`else
    localparam int FB = SB;
`endif

    typedef struct {
        logic [7:0] cmd0;
        logic [7:0] cmd1;
        bit         has1;
        int         halt_after;
        int         pause_after;
        bit         stall;
        int         exp_en;
        int         exp_rd;
        int         span;
    } vec_t;

    logic          clock = 1'b0;
    logic          reset_n;
    logic [DW-1:0] debug_signal;
    logic          cpu_halt;
    logic          cpu_enable;
    logic          rx_empty;
    logic [7:0]    r_data;
    logic          rd;
    logic          tx_full;
    logic [7:0]    w_data;
    logic          wr;

    debug_controller dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .debug_signal (debug_signal),
        .cpu_halt     (cpu_halt),
        .cpu_enable   (cpu_enable),
        .rx_empty     (rx_empty),
        .r_data       (r_data),
        .rd           (rd),
        .tx_full      (tx_full),
        .w_data       (w_data),
        .wr           (wr)
    );

    always #5 clock = ~clock;

    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] base;
    int            core_adv = 0;
    logic [31:0]   cyc_model = 0;
    int            cyc = 0;
    logic [7:0]    rxq[$];
    logic [7:0]    bytes_q[$];
    bit            last_rd = 0;
    int            halt_after = -1;
    int            pause_after = -1;
    bit            pause_done = 0;
    bit            stall = 0;
    int            local_en, local_rd, local_wr, wr_full_viol, en_halt_viol;
    int            first_rd, last_wr;
    vec_t          vecs[7];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_counts();
        local_en = 0; local_rd = 0; local_wr = 0;
        wr_full_viol = 0; en_halt_viol = 0;
        first_rd = -1; last_wr = -1;
        bytes_q.delete();
    endtask

    // One clock: drive inputs just after the edge, observe outputs at the falling edge.
    task automatic step();
        @(posedge clock);
        #1;
        if (last_rd && rxq.size() > 0) void'(rxq.pop_front());
        cyc++;
        cpu_halt = (halt_after >= 0) && (local_en >= halt_after);
        if (pause_after >= 0 && !pause_done && local_en == pause_after) begin
            rxq.push_back(8'h70);
            pause_done = 1;
        end
        rx_empty     = (rxq.size() == 0);
        r_data       = rx_empty ? 8'h00 : rxq[0];
        tx_full      = stall && cyc[0];
        debug_signal = base + DW'(core_adv);
        @(negedge clock);
        last_rd = rd;
        if (cpu_enable) begin
            local_en++;
            core_adv++;
            cyc_model = cyc_model + 32'd1;
            if (cpu_halt) en_halt_viol++;
        end
        if (rd) begin
            local_rd++;
            if (first_rd < 0) first_rd = cyc;
        end
        if (wr) begin
            local_wr++;
            last_wr = cyc;
            bytes_q.push_back(w_data);
            if (tx_full) wr_full_viol++;
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (2) step();
        reset_n = 1'b1;
        cyc_model = 0;
    endtask

    function automatic logic [7:0] exp_byte(input logic [DW-1:0] d, input logic [31:0] c, input int i);
        logic [8*SB-1:0] s;
        logic [8*FB-1:0] f;
        s = {d, 6'b000000};
`ifdef DEBUG_CYCLE_COUNT_EN
        f = {s, c};
`else
        f = s;
        if (c == 32'hFFFF_FFFF) f = '0;
`endif
        return f[8*FB-1-8*i -: 8];
    endfunction

    task automatic run_case(input vec_t v, input string tag);
        int            n;
        int            mism;
        int            adv0;
        logic [31:0]   cyc0;
        logic [DW-1:0] dexp;
        logic [31:0]   cexp;
        clear_counts();
        adv0 = core_adv;
        cyc0 = cyc_model;
        halt_after  = v.halt_after;
        pause_after = v.pause_after;
        pause_done  = 0;
        stall       = v.stall;
        rxq.push_back(v.cmd0);
        if (v.has1) rxq.push_back(v.cmd1);
        n = 0;
        while (local_wr < FB && n < 600) begin
            step();
            n++;
        end
        repeat (10) step();
        dexp = base + DW'(adv0 + v.exp_en);
        cexp = cyc0 + 32'(v.exp_en);
        chk({tag, " enable cycles"}, local_en, v.exp_en);
        chk({tag, " rd pops"}, local_rd, v.exp_rd);
        chk({tag, " wr count"}, local_wr, FB);
        chk({tag, " wr while tx_full"}, wr_full_viol, 0);
        chk({tag, " enable while halt"}, en_halt_viol, 0);
        mism = 0;
        for (int i = 0; i < bytes_q.size() && i < FB; i++) begin
            if (bytes_q[i] != exp_byte(dexp, cexp, i)) mism++;
        end
        chk({tag, " frame byte mismatches"}, mism, 0);
        chk({tag, " first byte"}, (bytes_q.size() > 0) ? bytes_q[0] : 8'hxx, dexp[DW-1 -: 8]);
        chk({tag, " last snapshot byte pad"}, (bytes_q.size() >= SB) ? (bytes_q[SB-1] & 8'h3F) : 8'hFF, 0);
        if (v.span >= 0) chk({tag, " pop to last byte"}, last_wr - first_rd, v.span);
        halt_after  = -1;
        pause_after = -1;
        stall       = 0;
    endtask

    initial begin
        vecs[0] = '{cmd0:8'h73, cmd1:8'h00, has1:0, halt_after:-1, pause_after:-1, stall:0, exp_en:1,  exp_rd:1, span:FB+2};
        vecs[1] = '{cmd0:8'h63, cmd1:8'h00, has1:0, halt_after:10, pause_after:-1, stall:0, exp_en:10, exp_rd:1, span:-1};
        vecs[2] = '{cmd0:8'h64, cmd1:8'h00, has1:0, halt_after:-1, pause_after:-1, stall:1, exp_en:0,  exp_rd:1, span:-1};
        vecs[3] = '{cmd0:8'h41, cmd1:8'h64, has1:1, halt_after:-1, pause_after:-1, stall:0, exp_en:0,  exp_rd:2, span:-1};
        vecs[4] = '{cmd0:8'h63, cmd1:8'h00, has1:0, halt_after:-1, pause_after:5,  stall:0, exp_en:6,  exp_rd:2, span:-1};
        vecs[5] = '{cmd0:8'h63, cmd1:8'h00, has1:0, halt_after:5,  pause_after:5,  stall:0, exp_en:5,  exp_rd:2, span:-1};
        vecs[6] = '{cmd0:8'h63, cmd1:8'h00, has1:0, halt_after:0,  pause_after:-1, stall:0, exp_en:0,  exp_rd:1, span:-1};

        base = '0;
        for (int i = 0; i < 11; i++) base = (base << 32) | DW'(32'h9E37_79B9 * (i + 1));
        debug_signal = base;
        cpu_halt = 1'b0;
        rx_empty = 1'b1;
        r_data   = 8'h00;
        tx_full  = 1'b0;
        clear_counts();

        // reset state, with a byte already waiting in the RX FIFO
        reset_n = 1'b0;
        rxq.push_back(8'h41);
        repeat (3) step();
        chk("reset rd", rd, 0);
        chk("reset cpu_enable", cpu_enable, 0);
        chk("reset wr", wr, 0);
        chk("reset w_data", w_data, 8'h00);
        reset_n = 1'b1;
        cyc_model = 0;
        clear_counts();
        repeat (5) step();
        chk("unknown byte popped", local_rd, 1);
        chk("unknown byte no wr", local_wr, 0);
        chk("unknown byte no enable", local_en, 0);
        chk("unknown byte fifo drained", rxq.size(), 0);

        for (int i = 0; i < 7; i++) run_case(vecs[i], $sformatf("vec%0d", i));

        // reset in the middle of a frame
        clear_counts();
        rxq.push_back(8'h64);
        for (int n = 0; n < 200 && local_wr < 20; n++) step();
        chk("abort reached byte 20", local_wr, 20);
        reset_n = 1'b0;
        repeat (2) step();
        reset_n = 1'b1;
        cyc_model = 0;
        clear_counts();
        repeat (60) step();
        chk("abort no wr after reset", local_wr, 0);
        chk("abort no enable after reset", local_en, 0);
        chk("abort w_data cleared", w_data, 8'h00);
        run_case(vecs[3], "post-abort");

`ifdef DEBUG_CYCLE_COUNT_EN
        do_reset();
        for (int k = 0; k < 3; k++) run_case(vecs[0], $sformatf("count%0d", k));
        chk("third frame trailing count",
            (bytes_q.size() == FB) ? {bytes_q[FB-4], bytes_q[FB-3], bytes_q[FB-2], bytes_q[FB-1]} : 32'hFFFF_FFFF,
            32'd3);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/debug_controller.md
# debug_controller

Host-facing debug controller downstream of the pipelined MIPS core. It consumes the core's packed `debug_signal` snapshot and drives the core's `enable`. Single-byte commands arrive from the UART receive FIFO; the block runs, single-steps or dumps the core, then serializes the captured snapshot MSB-first into the UART transmit FIFO.

## Interface
- `DEBUG_W`, default 322: width of `debug_signal` from the core, equal to `DEBUG`+1.
- `SNAP_BYTES`, default 41: frame length in bytes. Must satisfy 8·`SNAP_BYTES` ≥ `DEBUG_W`.
- `clock` in, 1: single clock; all state updates on the rising edge.
- `reset_n` in, 1: reset, synchronous and active-low.
- `debug_signal` in, `DEBUG_W`: core snapshot.
- `cpu_halt` in, 1: core reached its halt instruction; level signal.
- `cpu_enable` out, 1: drives the core's `enable`.
- `rx_empty` in, 1: UART RX FIFO empty.
- `r_data` in, 8: UART RX head byte; show-ahead, valid while `rx_empty`=0.
- `rd` out, 1: RX pop, one-cycle pulse.
- `tx_full` in, 1: UART TX FIFO full.
- `w_data` out, 8: TX byte.
- `wr` out, 1: TX push, one-cycle pulse per byte.

## Operation
- States:
  - IDLE: `rd`=1 whenever `rx_empty`=0; `r_data` is decoded in the same cycle.
  - From IDLE on the decoded command:
    - 0x63 'c' goes to RUN.
    - 0x73 's' goes to STEP.
    - 0x64 'd' goes to CAPTURE.
    - Any other byte is popped and discarded; state stays IDLE.
  - RUN:
    - `cpu_enable` = !`cpu_halt` (combinational).
    - `rd`=1 when `rx_empty`=0.
    - Popped byte 0x70 'p' goes to CAPTURE; other popped bytes are discarded.
    - `cpu_halt`=1 goes to CAPTURE.
    - 'p' and halt in the same cycle produce one CAPTURE only.
  - STEP: `cpu_enable`=1 for exactly one cycle, then CAPTURE.
  - CAPTURE: `cpu_enable`=0. The frame register loads {`debug_signal`, zero pad} left-aligned to 8·`SNAP_BYTES` bits, byte counter = 0. Next state is SEND.
  - SEND:
    - When `tx_full`=0: `wr`=1, `w_data` = frame[top byte], frame shifts left 8, counter increments.
    - When `tx_full`=1: `wr`=0, nothing changes.
    - After byte `SNAP_BYTES`-1 is written, go to IDLE.
- `cpu_enable` is 0 in every state except RUN and STEP.
- `rd` is never asserted outside IDLE and RUN. Commands arriving during SEND wait in the RX FIFO.
- Entering RUN with `cpu_halt` already 1: `cpu_enable` never rises; CAPTURE follows next cycle.
- Reset values:
  - State is IDLE.
  - `cpu_enable`, `rd` and `wr` are 0.
  - `w_data` is 0x00, the frame register is 0 and the byte counter is 0.
- Reset during SEND aborts the frame. No further `wr` pulses occur.

## Timing
- Command pop to state change: 1 cycle.
  - The `rd` cycle decodes the command.
  - The next cycle is in RUN, STEP or CAPTURE.
- STEP: the core advances exactly one clock. CAPTURE samples `debug_signal` on the edge after that step cycle.
- CAPTURE to first `wr`: 1 cycle. SEND lasts ≥ `SNAP_BYTES` cycles, plus one cycle per `tx_full` stall.
- Command pop to last byte written, for 's' with no stalls: 1+1+1+41 = 44 cycles.
- `w_data` is valid in the same cycle as `wr`. It holds its last value otherwise.

## Configuration
- `DEBUG_CYCLE_COUNT_EN` defined:
  - A 32-bit counter increments on every cycle with `cpu_enable`=1.
  - It wraps 0xFFFFFFFF→0 and is cleared only by reset.
  - CAPTURE appends it, MSB first, after the snapshot. The frame becomes `SNAP_BYTES`+4 bytes.
- `DEBUG_CYCLE_COUNT_EN` undefined: no counter is built and the frame is `SNAP_BYTES` bytes.

## Structure
- Shared package `debug_pkg`:
  - Command constants CMD_RUN 8'h63, CMD_STEP 8'h73, CMD_DUMP 8'h64, CMD_PAUSE 8'h70.
  - State encoding.
  - Default `SNAP_BYTES`.
- One sub-module, `debug_tx_serializer`:
  - Holds the frame shift register, byte counter and `wr`/`tx_full` handshake.
  - Has a load strobe and a done pulse.
- `debug_controller` keeps the command FSM and the enable generation.

## Test plan
- Reset, then 's' in RX FIFO → `rd` pulse; `cpu_enable` high exactly 1 cycle; 41 `wr` pulses; first `w_data` = `debug_signal`[321:314]; last byte low 6 bits = 0.
- 'c', core raises `cpu_halt` after 10 enabled cycles → `cpu_enable` high 10 cycles, drops the same cycle halt rises, then 41-byte frame.
- 'c', then 'p' pushed while running → run stops the cycle after the pop; one frame only. With `cpu_halt` asserted in that same cycle → still one frame.
- 'd' with `tx_full` toggling 1/0 every other cycle → `cpu_enable` never high; exactly 41 `wr`, none while `tx_full`=1; byte order intact.
- Unknown byte 0x41, then 'd' → 0x41 popped with no effect; one frame follows. Reset asserted after byte 20 of a frame → `wr` stays 0; state IDLE.
- With `DEBUG_CYCLE_COUNT_EN`: 's' three times → third frame is 45 bytes, trailing 0x00000003.
